// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: PC select codes, hazard FSM states, register-number width.
package pipeline_hazard_ctrl_pkg;
    localparam int REG_W = 5;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en && (count != '1))
            count <= count + W'(1);
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: memory hold, branch/jump redirect, load-use stall,
// plus saturating stall and flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ID_EX_MemRead,
    input  logic [REG_W-1:0]   ID_EX_RegisterRt,
    input  logic [REG_W-1:0]   IF_ID_RegisterRs,
    input  logic [REG_W-1:0]   IF_ID_RegisterRt,
    input  logic               EX_MEM_Branch,
    input  logic               EX_MEM_ALU_zero,
    input  logic               EX_MEM_Jump,
    input  logic               EX_MEM_MemRead,
    input  logic               EX_MEM_MemWrite,
    input  logic               dmem_ready,
    output logic               PC_Write,
    output logic               IF_ID_Write,
    output logic               ID_EX_Write,
    output logic               EX_MEM_Write,
    output logic               IF_Flush,
    output logic               ID_Flush,
    output logic               EX_Flush,
    output logic               MEM_WB_Flush,
    output logic [1:0]         PC_Src,
    output logic               dmem_req,
    output logic               mem_err,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t         state, next_state;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic           mem_acc, hold, taken, load_use, err_set, flush_evt, stall_en;

    assign mem_acc = EX_MEM_MemRead | EX_MEM_MemWrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
            if (err_set)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        wait_nxt     = wait_cnt;
        err_set      = 1'b0;
        hold         = 1'b0;
        dmem_req     = 1'b0;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_Flush     = 1'b0;
        ID_Flush     = 1'b0;
        EX_Flush     = 1'b0;
        MEM_WB_Flush = 1'b0;
        PC_Src       = PCSRC_SEQ;

        case (state)
            ST_RUN: begin
                if (mem_acc) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        hold       = 1'b1;
                        next_state = ST_MEM_WAIT;
                        wait_nxt   = WCW'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    next_state = ST_RUN;
                    wait_nxt   = '0;
                end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                    // Abandon: this cycle releases the pipeline with undefined load data.
                    next_state = ST_RUN;
                    wait_nxt   = '0;
                    err_set    = 1'b1;
                end else begin
                    hold     = 1'b1;
                    wait_nxt = wait_cnt + WCW'(1);
                end
            end
            default: begin
                next_state = ST_RUN;
                wait_nxt   = '0;
            end
        endcase

        taken    = !hold && ((EX_MEM_Branch && EX_MEM_ALU_zero) || EX_MEM_Jump);
        load_use = !hold && !taken && ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
                   ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt));

        if (hold) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (taken) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
            EX_Flush = 1'b1;
            PC_Src   = EX_MEM_Jump ? PCSRC_JMP : PCSRC_BR;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_Flush    = 1'b1;
        end

        if (rst) begin
            err_set      = 1'b0;
            dmem_req     = 1'b0;
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            IF_Flush     = 1'b0;
            ID_Flush     = 1'b0;
            EX_Flush     = 1'b0;
            MEM_WB_Flush = 1'b0;
            PC_Src       = PCSRC_SEQ;
        end
    end

    assign stall_en  = !rst && !PC_Write;
    assign flush_evt = !rst && taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_evt),
        .count (flush_events)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, monitor pops and compares.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 16;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic       rst, idex_rd;
        logic [4:0] idex_rt, ifid_rs, ifid_rt;
        logic       br, z, j, rd, wr, ready;
    } stim_t;

    typedef struct packed {
        logic [3:0]    wr;   // PC, IF_ID, ID_EX, EX_MEM
        logic [3:0]    fl;   // IF, ID, EX, MEM_WB
        logic [1:0]    pcs;
        logic          req, err;
        logic [CW-1:0] stall, flush;
    } exp_t;

    logic clk = 1'b0, rst;
    logic ID_EX_MemRead, EX_MEM_Branch, EX_MEM_ALU_zero, EX_MEM_Jump;
    logic EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready;
    logic [4:0] ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic IF_Flush, ID_Flush, EX_Flush, MEM_WB_Flush, dmem_req, mem_err;
    logic [1:0] PC_Src;
    logic [CW-1:0] stall_cycles, flush_events;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALU_zero(EX_MEM_ALU_zero), .EX_MEM_Jump(EX_MEM_Jump),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .dmem_ready(dmem_ready),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
        .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush), .MEM_WB_Flush(MEM_WB_Flush),
        .PC_Src(PC_Src), .dmem_req(dmem_req), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;

    // Reference model state: hold cycles already spent on the current access, sticky error, counters.
    int m_waited = 0, m_stall = 0, m_flush = 0;
    bit m_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic cycle(input stim_t s);
        exp_t e;
        bit busy, stall_now, tout, hold, taken, lu;
        @(posedge clk);
        #1;
        rst = s.rst; ID_EX_MemRead = s.idex_rd; ID_EX_RegisterRt = s.idex_rt;
        IF_ID_RegisterRs = s.ifid_rs; IF_ID_RegisterRt = s.ifid_rt;
        EX_MEM_Branch = s.br; EX_MEM_ALU_zero = s.z; EX_MEM_Jump = s.j;
        EX_MEM_MemRead = s.rd; EX_MEM_MemWrite = s.wr; dmem_ready = s.ready;

        e = '0;
        e.err = m_err; e.stall = CW'(m_stall); e.flush = CW'(m_flush);
        if (s.rst) begin
            m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            busy  = (m_waited > 0) || s.rd || s.wr;
            hold  = busy && !s.ready && (m_waited + 1 < TO);
            tout  = busy && !s.ready && (m_waited + 1 >= TO);
            taken = !hold && ((s.br && s.z) || s.j);
            lu    = !hold && !taken && s.idex_rd && s.idex_rt != 0 &&
                    (s.idex_rt == s.ifid_rs || s.idex_rt == s.ifid_rt);
            stall_now = hold || lu;
            e.wr  = {!stall_now, !stall_now, !hold, !hold};
            e.fl  = {taken, taken || lu, taken, hold};
            e.pcs = taken ? (s.j ? 2'b10 : 2'b01) : 2'b00;
            e.req = busy;
            m_waited = hold ? m_waited + 1 : 0;
            if (tout) m_err = 1;
            if (stall_now && m_stall < SAT) m_stall++;
            if (taken && m_flush < SAT) m_flush++;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.wr = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write};
            a.fl = {IF_Flush, ID_Flush, EX_Flush, MEM_WB_Flush};
            a.pcs = PC_Src; a.req = dmem_req; a.err = mem_err;
            a.stall = stall_cycles; a.flush = flush_events;
            chk("cycle_outputs", 64'(a), 64'(e));
        end
    end

    initial begin
        stim_t s;
        int pct;
        rst = 1'b1; ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
        EX_MEM_Branch = 0; EX_MEM_ALU_zero = 0; EX_MEM_Jump = 0;
        EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; dmem_ready = 0;

        // Reset, then reset again in the middle of a memory wait.
        s = idle(); s.rst = 1; cycle(s); cycle(s);
        s = idle(); s.rd = 1; cycle(s); cycle(s); cycle(s);
        s = idle(); s.rst = 1; s.rd = 1; cycle(s); cycle(s);
        cycle(idle());
        chk("reset_stall_cnt", 64'(stall_cycles), 64'(0));
        chk("reset_mem_err", 64'(mem_err), 64'(0));

        // Load-use on Rs, then the same with Rt = 0.
        s = idle(); s.idex_rd = 1; s.idex_rt = 5; s.ifid_rs = 5; cycle(s);
        cycle(idle());
        chk("loaduse_stall_cnt", 64'(stall_cycles), 64'(1));
        s.idex_rt = 0; s.ifid_rs = 0; cycle(s);
        cycle(idle());
        chk("loaduse_r0_stall_cnt", 64'(stall_cycles), 64'(1));

        // Branch taken, branch+jump, branch not taken.
        s = idle(); s.rst = 1; cycle(s);
        s = idle(); s.br = 1; s.z = 1; cycle(s);
        cycle(idle());
        chk("branch_flush_cnt", 64'(flush_events), 64'(1));
        s.j = 1; cycle(s);
        s = idle(); s.br = 1; cycle(s);
        cycle(idle());
        chk("branch_nt_flush_cnt", 64'(flush_events), 64'(2));

        // Multi-cycle access, ready on the 4th cycle.
        s = idle(); s.rst = 1; cycle(s);
        s = idle(); s.rd = 1; cycle(s); cycle(s); cycle(s);
        s.ready = 1; cycle(s);
        cycle(idle());
        chk("memwait_stall_cnt", 64'(stall_cycles), 64'(3));

        // Timeout: ready never arrives.
        s = idle(); s.rst = 1; cycle(s);
        s = idle(); s.wr = 1;
        for (int i = 0; i < TO; i++) cycle(s);
        cycle(idle());
        chk("timeout_mem_err", 64'(mem_err), 64'(1));
        for (int i = 0; i < 5; i++) cycle(idle());
        chk("timeout_err_sticky", 64'(mem_err), 64'(1));
        s = idle(); s.rst = 1; cycle(s);
        cycle(idle());
        chk("err_cleared_by_rst", 64'(mem_err), 64'(0));

        // Saturation: 20 load-use stalls on a 4-bit counter.
        s = idle(); s.idex_rd = 1; s.idex_rt = 7; s.ifid_rt = 7;
        for (int i = 0; i < 20; i++) cycle(s);
        cycle(idle());
        chk("stall_saturation", 64'(stall_cycles), 64'(SAT));

        // Randomized traffic with varying memory latency.
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pct = (($urandom % 3) == 0) ? 0 : ((($urandom % 2) == 0) ? 30 : 90);
            s.rst     = (($urandom % 100) == 0);
            s.idex_rd = $urandom % 2;
            s.idex_rt = 5'($urandom % 4);
            s.ifid_rs = 5'($urandom % 4);
            s.ifid_rt = 5'($urandom % 4);
            s.br      = $urandom % 2;
            s.z       = $urandom % 2;
            s.j       = (($urandom % 4) == 0);
            s.rd      = (($urandom % 4) == 0);
            s.wr      = (($urandom % 6) == 0);
            s.ready   = (($urandom % 100) < pct);
            cycle(s);
        end

        @(posedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
